// File: rtl/multiplier_4bit.sv
// multiplier_4bit: 4x4 unsigned array multiplier with a same-cycle product
// and a one-cycle registered copy.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset (clears product_q/valid_q only)
//   A, B       4-bit unsigned operands
//   product    combinational A*B (0..225), independent of clk/rst
//   product_q  A*B captured at the previous rising edge
//   valid_q    set by the first non-reset edge, cleared by reset
module multiplier_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] product,
  output logic [7:0] product_q,
  output logic       valid_q
);

  localparam int unsigned OpW   = 4;
  localparam int unsigned ProdW = 2 * OpW;

  // Half adder: {carry, sum}.
  function automatic logic [1:0] half_add(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  // Full adder: {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b,
                                          input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  logic [ProdW-1:0] product_d;
  logic [OpW-1:0]   acc;
  logic [OpW-1:0]   row_x;
  logic [OpW-1:0]   row_pp;
  logic             acc_top;
  logic             carry;

  // Partial-product array: row i is A & B[i]. Each row is ripple-added to
  // the running partial sum shifted right by one; the bit shifted out is a
  // finished product bit, and the last row's carry becomes product[7].
  always_comb begin
    product_d = '0;
    acc       = A & {OpW{B[0]}};
    acc_top   = 1'b0;
    row_x     = '0;
    row_pp    = '0;
    carry     = 1'b0;
    product_d[0] = acc[0];
    for (int i = 1; i < OpW; i++) begin
      row_x  = {acc_top, acc[OpW-1:1]};
      row_pp = A & {OpW{B[i]}};
      carry  = 1'b0;
      for (int j = 0; j < OpW; j++) begin
        if (j == 0) begin
          {carry, acc[2'(j)]} = half_add(row_x[2'(j)], row_pp[2'(j)]);
        end else begin
          {carry, acc[2'(j)]} = full_add(row_x[2'(j)], row_pp[2'(j)], carry);
        end
      end
      acc_top = carry;
      product_d[3'(i)] = acc[0];
    end
    product_d[ProdW-1:OpW] = {acc_top, acc[OpW-1:1]};
  end

  assign product = product_d;

  // Pipeline register; reset affects only the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      product_q <= product_d;
      valid_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multiplier_4bit.sv
// Self-checking bench for multiplier_4bit against plain integer multiplication.
module tb_multiplier_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] product;
  logic [7:0] product_q;
  logic       valid_q;

  int checks = 0;
  int errors = 0;

  multiplier_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .product   (product),
    .product_q (product_q),
    .valid_q   (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input int a, input int b);
    return 8'(a * b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_vectors();
    int va [7] = '{0, 5, 14, 11, 6, 9, 13};
    int vb [7] = '{0, 3, 0, 1, 15, 2, 10};
    int ve [7] = '{8'h00, 8'h0F, 8'h00, 8'h0B, 8'h5A, 8'h12, 8'h82};
    for (int k = 0; k < 7; k++) begin
      A = 4'(va[k]);
      B = 4'(vb[k]);
      #2;
      checks++;
      if (product !== 8'(ve[k])) begin
        errors++;
        $display("FAIL comb_vec A=%0d B=%0d got %h want %h", va[k], vb[k], product, 8'(ve[k]));
      end
    end
  endtask

  task automatic test_boundary();
    int va [3] = '{15, 15, 1};
    int vb [3] = '{15, 1, 15};
    int ve [3] = '{8'hE1, 8'h0F, 8'h0F};
    for (int k = 0; k < 3; k++) begin
      A = 4'(va[k]);
      B = 4'(vb[k]);
      #2;
      checks++;
      if (product !== 8'(ve[k])) begin
        errors++;
        $display("FAIL boundary A=%0d B=%0d got %h want %h", va[k], vb[k], product, 8'(ve[k]));
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        #2;
        checks++;
        if ($isunknown(product) || product !== model(a, b)) begin
          errors++;
          $display("FAIL exhaustive A=%0d B=%0d got %h want %h", a, b, product, model(a, b));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A = 4'd7;
    B = 4'd9;
    tick();
    tick();
    checks++;
    if (product_q !== 8'h00 || valid_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got q=%h v=%b want q=00 v=0", product_q, valid_q);
    end
    checks++;
    if (product !== model(7, 9)) begin
      errors++;
      $display("FAIL reset_comb got %h want %h", product, model(7, 9));
    end
  endtask

  task automatic test_registered();
    rst = 1'b0;
    A = 4'd13;
    B = 4'd10;
    tick();
    checks++;
    if (product_q !== 8'h82 || valid_q !== 1'b1) begin
      errors++;
      $display("FAIL release got q=%h v=%b want q=82 v=1", product_q, valid_q);
    end
    A = 4'd6;
    B = 4'd15;
    tick();
    checks++;
    if (product_q !== 8'h5A) begin
      errors++;
      $display("FAIL reg_second got %h want 5a", product_q);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    int b;
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      A = 4'(a);
      B = 4'(b);
      tick();
      checks++;
      if (product_q !== model(a, b) || valid_q !== 1'b1) begin
        errors++;
        $display("FAIL b2b A=%0d B=%0d got q=%h v=%b want q=%h v=1", a, b, product_q, valid_q, model(a, b));
      end
    end
  endtask

  task automatic test_midstream_reset();
    int a;
    int b;
    for (int k = 0; k < 8; k++) begin
      a = int'($urandom_range(15, 1));
      b = int'($urandom_range(15, 1));
      A = 4'(a);
      B = 4'(b);
      tick();
    end
    rst = 1'b1;
    a = int'($urandom_range(15, 1));
    b = int'($urandom_range(15, 1));
    A = 4'(a);
    B = 4'(b);
    tick();
    checks++;
    if (product_q !== 8'h00 || valid_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got q=%h v=%b want q=00 v=0", product_q, valid_q);
    end
    checks++;
    if (product !== model(a, b)) begin
      errors++;
      $display("FAIL mid_reset_comb got %h want %h", product, model(a, b));
    end
    rst = 1'b0;
    a = int'($urandom_range(15, 1));
    b = int'($urandom_range(15, 1));
    A = 4'(a);
    B = 4'(b);
    tick();
    checks++;
    if (product_q !== model(a, b) || valid_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got q=%h v=%b want q=%h v=1", product_q, valid_q, model(a, b));
    end
  endtask

  initial begin
    rst = 1'b1;
    A = 4'd0;
    B = 4'd0;
    test_comb_vectors();
    test_boundary();
    test_exhaustive();
    test_reset();
    test_registered();
    test_back_to_back();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
